// File: rtl/grant_decoder_arbiter_if.sv
// rtl/grant_decoder_arbiter_if.sv - requester-side bundle for the shared one-hot select arbiter
// Signals:
//   req      [7:0] level request, one bit per requester
//   rel            granted requester is done (release strobe)
//   gnt_en         grant active (decoder enable)
//   gnt_idx  [2:0] index of the granted requester
//   gnt      [7:0] one-hot grant, decode of gnt_idx qualified by gnt_en
//   busy           arbiter not idle
//   timeout        one-cycle pulse marking a forced grant end
// Modports: master = requesting agents, slave = arbiter.
interface grant_decoder_arbiter_if;
    logic [7:0] req;
    logic       rel;
    logic       gnt_en;
    logic [2:0] gnt_idx;
    logic [7:0] gnt;
    logic       busy;
    logic       timeout;

    modport master (
        output req, rel,
        input  gnt_en, gnt_idx, gnt, busy, timeout
    );

    modport slave (
        input  req, rel,
        output gnt_en, gnt_idx, gnt, busy, timeout
    );
endinterface

// File: rtl/grant_decoder_arbiter.sv
// rtl/grant_decoder_arbiter.sv - round-robin arbiter driving a 3-to-8 one-hot select
// Parameters:
//   MAX_HOLD  maximum cycles one grant may last (2..256)
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  grant_decoder_arbiter_if.slave (req, rel in; gnt_en, gnt_idx, gnt, busy, timeout out)
module grant_decoder_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    grant_decoder_arbiter_if.slave  bus
);
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t        state;
    logic [2:0]    ptr;
    logic [CW-1:0] hold_cnt;
    logic          gnt_en_q;
    logic [2:0]    gnt_idx_q;
    logic          timeout_q;

    logic [7:0]    rot;
    logic [2:0]    pick_ofs;
    logic [2:0]    pick_idx;
    logic          withdraw;
    logic          forced;

    // Rotate the request vector so bit 0 is the requester at ptr, find the
    // lowest set bit, then rotate the offset back to an absolute index.
    always_comb begin
        rot      = 8'({bus.req, bus.req} >> ptr);
        pick_ofs = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) begin
                pick_ofs = 3'(i);
            end
        end
        pick_idx = ptr + pick_ofs;
    end

    always_comb begin
        withdraw = ~bus.req[gnt_idx_q];
        forced   = (hold_cnt == HOLD_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hold_cnt  <= '0;
            gnt_en_q  <= 1'b0;
            gnt_idx_q <= 3'd0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req != 8'h00) begin
                        gnt_idx_q <= pick_idx;
                        gnt_en_q  <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.rel || withdraw || forced) begin
                        gnt_en_q  <= 1'b0;
                        state     <= RECOVER;
                        ptr       <= gnt_idx_q + 3'd1;
                        // A release or withdrawal at the hold limit is a normal end.
                        timeout_q <= forced && !bus.rel && !withdraw;
                    end else begin
                        hold_cnt  <= hold_cnt + 1'b1;
                    end
                end
                RECOVER: begin
                    timeout_q <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    gnt_en_q  <= 1'b0;
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

    // gnt is a pure decode of registers, so reset clears it without a clock edge.
    assign bus.gnt_en  = gnt_en_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.gnt     = gnt_en_q ? (8'h01 << gnt_idx_q) : 8'h00;
    assign bus.busy    = (state != IDLE);
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_grant_decoder_arbiter.sv
// tb/tb_grant_decoder_arbiter.sv - directed self-checking bench for grant_decoder_arbiter
module tb_grant_decoder_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    grant_decoder_arbiter_if bus();

    grant_decoder_arbiter #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_idx,
                           input logic e_en, input logic e_busy, input logic e_to);
        chk({tag, ".gnt"},     32'(bus.gnt),     32'(e_gnt));
        chk({tag, ".gnt_idx"}, 32'(bus.gnt_idx), 32'(e_idx));
        chk({tag, ".gnt_en"},  32'(bus.gnt_en),  32'(e_en));
        chk({tag, ".busy"},    32'(bus.busy),    32'(e_busy));
        chk({tag, ".timeout"}, 32'(bus.timeout), 32'(e_to));
    endtask

    initial begin
        logic [7:0] oh;
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        bus.req = 8'h00;
        bus.rel = 1'b0;
        tick();
        tick();
        chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("idle_no_req", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // Single request to index 5, release on the 3rd grant cycle
        bus.req = 8'b0010_0000;
        tick();
        chk_out("single_c1", 8'h20, 3'd5, 1'b1, 1'b1, 1'b0);
        tick();
        chk("single_c2.gnt", 32'(bus.gnt), 32'h20);
        tick();
        chk("single_c3.gnt", 32'(bus.gnt), 32'h20);
        bus.rel = 1'b1;
        tick();
        chk_out("single_rel", 8'h00, 3'd5, 1'b0, 1'b1, 1'b0);
        bus.rel = 1'b0;
        bus.req = 8'h00;
        tick();
        chk_out("single_idle", 8'h00, 3'd5, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a grant
        bus.req = 8'b0010_0000;
        tick();
        chk("rst_pre.gnt", 32'(bus.gnt), 32'h20);
        #2;
        rst = 1'b1;
        #1;
        chk_out("rst_async", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        bus.req = 8'h00;
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk_out("rst_after", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // Round robin with all requesters active, release on 2nd grant cycle
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            oh = 8'h01 << (k % 8);
            tick();
            chk_out($sformatf("rr%0d_c1", k), oh, 3'(k % 8), 1'b1, 1'b1, 1'b0);
            tick();
            chk($sformatf("rr%0d_c2.gnt", k), 32'(bus.gnt), 32'(oh));
            bus.rel = 1'b1;
            tick();
            chk($sformatf("rr%0d_gap1.gnt", k), 32'(bus.gnt), 32'h00);
            bus.rel = 1'b0;
            if (k == 8) bus.req = 8'h00;
            tick();
            chk($sformatf("rr%0d_gap2.gnt", k), 32'(bus.gnt), 32'h00);
        end

        // Forced end after MAX_HOLD=4 cycles, then wrap back to the same requester
        bus.req = 8'h08;
        tick();
        chk_out("to_c1", 8'h08, 3'd3, 1'b1, 1'b1, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk($sformatf("to_c%0d.gnt", c), 32'(bus.gnt), 32'h08);
            chk($sformatf("to_c%0d.timeout", c), 32'(bus.timeout), 32'h0);
        end
        tick();
        chk_out("to_end", 8'h00, 3'd3, 1'b0, 1'b1, 1'b1);
        tick();
        chk_out("to_idle", 8'h00, 3'd3, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("to_regrant", 8'h08, 3'd3, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk("to_rel_c4.gnt", 32'(bus.gnt), 32'h08);
        bus.rel = 1'b1;
        tick();
        chk_out("to_rel_end", 8'h00, 3'd3, 1'b0, 1'b1, 1'b0);
        bus.rel = 1'b0;
        bus.req = 8'h00;
        tick();
        chk("to_rel_idle.timeout", 32'(bus.timeout), 32'h0);

        // Grant to 7, then wrap to 0, then withdrawal ends the grant
        bus.req = 8'h80;
        tick();
        chk_out("wrap_g7", 8'h80, 3'd7, 1'b1, 1'b1, 1'b0);
        bus.rel = 1'b1;
        tick();
        bus.rel = 1'b0;
        bus.req = 8'b1000_0001;
        tick();
        tick();
        chk_out("wrap_g0", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
        tick();
        bus.req = 8'h80;
        tick();
        chk_out("withdraw_end", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        bus.req = 8'h00;
        tick();
        chk("withdraw_idle.timeout", 32'(bus.timeout), 32'h0);

        // Masking of other requesters during a grant
        bus.req = 8'h04;
        tick();
        chk_out("mask_c1", 8'h04, 3'd2, 1'b1, 1'b1, 1'b0);
        bus.req = 8'h7C;
        tick();
        chk("mask_c2.gnt", 32'(bus.gnt), 32'h04);
        bus.req = 8'h2C;
        tick();
        chk("mask_c3.gnt", 32'(bus.gnt), 32'h04);
        bus.req = 8'h0C;
        bus.rel = 1'b1;
        tick();
        chk_out("mask_rel", 8'h00, 3'd2, 1'b0, 1'b1, 1'b0);
        bus.rel = 1'b0;
        tick();
        chk("mask_gap.gnt", 32'(bus.gnt), 32'h00);
        tick();
        chk_out("mask_next", 8'h08, 3'd3, 1'b1, 1'b1, 1'b0);
        bus.rel = 1'b1;
        tick();
        bus.rel = 1'b0;
        bus.req = 8'h00;
        tick();
        chk_out("final_idle", 8'h00, 3'd3, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
